// File: rtl/serdes_pkg.sv
// Shared receive-path constants: comma symbols, symbol width, aligner states.
// Included by word_aligner, comma_match and word_aligner_if.
package serdes_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] COMMA_P = 10'b0011111010;
    localparam logic [SYM_W-1:0] COMMA_N = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } aligner_state_t;

endpackage

// File: rtl/word_aligner_if.sv
// Bundle between the serial source, the aligner and the decoder/link controller.
// master drives the serial side; slave is the aligner itself.
interface word_aligner_if;
    import serdes_pkg::*;

    logic             sdin;
    logic             align_en;
    logic [SYM_W-1:0] dout;
    logic             dout_valid;
    logic             locked;
    logic             comma_det;

    modport master (
        output sdin,
        output align_en,
        input  dout,
        input  dout_valid,
        input  locked,
        input  comma_det
    );

    modport slave (
        input  sdin,
        input  align_en,
        output dout,
        output dout_valid,
        output locked,
        output comma_det
    );

endinterface

// File: rtl/word_aligner_comma_match.sv
// K28.5 comma compare on the 10-bit shift window.
// ALIGNER_NEG_COMMA_EN adds the negative-disparity form to the match.
module comma_match
    import serdes_pkg::*;
(
    input  logic [SYM_W-1:0] sr,
    output logic             match
);

`ifdef ALIGNER_NEG_COMMA_EN
    assign match = (sr == COMMA_P) || (sr == COMMA_N);
`else
    assign match = (sr == COMMA_P);
`endif

endmodule

// File: rtl/word_aligner.sv
// Serial-to-parallel word aligner: comma hunt, verify, lock and loss tracking.
// Optional ALIGNER_NEG_COMMA_EN (see comma_match) also accepts the negative comma.
module word_aligner
    import serdes_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2
) (
    input logic           clk,
    input logic           reset,
    word_aligner_if.slave bus
);

    typedef logic [7:0] cnt_t;

    localparam cnt_t LOCK_N = cnt_t'(LOCK_CNT);
    localparam cnt_t LOSS_N = cnt_t'(LOSS_CNT);

    logic [SYM_W-1:0] sr;
    logic [3:0]       bcnt;
    cnt_t             good_cnt;
    cnt_t             bad_cnt;
    aligner_state_t   state;
    logic             match;
    logic             at_bnd;
    logic             hit;

    comma_match u_match (
        .sr    (sr),
        .match (match)
    );

    assign at_bnd = (bcnt == 4'd0);
    assign hit    = match && bus.align_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= HUNT;
            sr             <= '0;
            bcnt           <= '0;
            good_cnt       <= '0;
            bad_cnt        <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.locked     <= 1'b0;
            bus.comma_det  <= 1'b0;
        end else begin
            sr             <= {sr[SYM_W-2:0], bus.sdin};
            bus.dout_valid <= 1'b0;
            bus.comma_det  <= 1'b0;
            unique case (state)
                HUNT: begin
                    // the aligning comma itself is good comma number one
                    if (hit) begin
                        bus.dout       <= sr;
                        bus.dout_valid <= 1'b1;
                        bus.comma_det  <= 1'b1;
                        bcnt           <= 4'd1;
                        good_cnt       <= 8'd1;
                        bad_cnt        <= '0;
                        if (LOCK_CNT == 1) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                        end else begin
                            state      <= VERIFY;
                        end
                    end
                end
                VERIFY, LOCKED: begin
                    bcnt <= (bcnt == 4'd9) ? 4'd0 : bcnt + 4'd1;
                    if (at_bnd) begin
                        bus.dout       <= sr;
                        bus.dout_valid <= 1'b1;
                        bus.comma_det  <= match;
                    end
                    if (hit && at_bnd) begin
                        if (state == VERIFY) begin
                            good_cnt <= good_cnt + 8'd1;
                            if (good_cnt + 8'd1 == LOCK_N) begin
                                state      <= LOCKED;
                                bus.locked <= 1'b1;
                            end
                        end else begin
                            bad_cnt <= '0;
                        end
                    end else if (hit) begin
                        // VERIFY drops on the first slip, LOCKED tolerates a few
                        if (state == VERIFY || bad_cnt + 8'd1 == LOSS_N) begin
                            state      <= HUNT;
                            bus.locked <= 1'b0;
                            good_cnt   <= '0;
                            bad_cnt    <= '0;
                            bcnt       <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state      <= HUNT;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
